// File: rtl/bus_decoder.sv
// bus_decoder: power-of-two region decoder and single-outstanding
// request sequencer with miss, write-protect and ack-timeout faults.
module bus_decoder #(
  parameter int unsigned N_REGIONS = 3,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter logic [N_REGIONS*ADDR_W-1:0] REGION_BASE =
    {32'h4000_0000, 32'h8000_2000, 32'h8000_0000},
  parameter logic [N_REGIONS*ADDR_W-1:0] REGION_SIZE =
    {32'h0000_0004, 32'h0000_2000, 32'h0000_2000},
  parameter logic [N_REGIONS-1:0] REGION_RO = 3'b001,
  parameter int unsigned TIMEOUT   = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [ADDR_W-1:0]             req_addr,
  input  logic                          req_we,
  input  logic [DATA_W-1:0]             req_wdata,
  input  logic [DATA_W/8-1:0]           req_wstrb,
  output logic                          resp_valid,
  output logic [DATA_W-1:0]             resp_rdata,
  output logic                          resp_err,
  output logic [N_REGIONS-1:0]          s_sel,
  output logic [ADDR_W-1:0]             s_addr,
  output logic                          s_we,
  output logic [DATA_W-1:0]             s_wdata,
  output logic [DATA_W/8-1:0]           s_wstrb,
  input  logic [N_REGIONS-1:0]          s_ack,
  input  logic [N_REGIONS*DATA_W-1:0]   s_rdata,
  output logic [7:0]                    err_count
);

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  state_t state;
  logic [7:0] cnt;

  logic [N_REGIONS-1:0] dec_sel;
  logic [ADDR_W-1:0]    dec_mask;
  logic                 dec_hit;
  logic                 dec_ro;
  logic                 ack_hit;
  logic [DATA_W-1:0]    sel_rdata;

  function automatic logic [ADDR_W-1:0] region_mask(input int i);
    return REGION_SIZE[i*ADDR_W +: ADDR_W] - ADDR_W'(1);
  endfunction

  assign req_ready = (state == IDLE);

  // Region match; scanning downward lets the lowest index win.
  always_comb begin
    dec_sel  = '0;
    dec_mask = '0;
    for (int i = N_REGIONS - 1; i >= 0; i--) begin
      if ((req_addr & ~region_mask(i)) ==
          REGION_BASE[i*ADDR_W +: ADDR_W]) begin
        dec_sel    = '0;
        dec_sel[i] = 1'b1;
        dec_mask   = region_mask(i);
      end
    end
  end

  assign dec_hit = |dec_sel;
  assign dec_ro  = |(dec_sel & REGION_RO);
  assign ack_hit = |(s_ack & s_sel);

  // Read data of the selected slave only.
  always_comb begin
    sel_rdata = '0;
    for (int i = 0; i < N_REGIONS; i++) begin
      sel_rdata = sel_rdata |
        ({DATA_W{s_sel[i]}} & s_rdata[i*DATA_W +: DATA_W]);
    end
  end

  // Transaction sequencer with registered slave and response outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
      s_sel      <= '0;
      s_addr     <= '0;
      s_we       <= 1'b0;
      s_wdata    <= '0;
      s_wstrb    <= '0;
      err_count  <= '0;
    end else begin
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
      if (resp_valid && resp_err && err_count != 8'hFF)
        err_count <= err_count + 8'd1;
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            if (!dec_hit || (dec_ro && req_we)) begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
            end else begin
              state   <= ACCESS;
              cnt     <= '0;
              s_sel   <= dec_sel;
              s_addr  <= req_addr & dec_mask;
              s_we    <= req_we;
              s_wdata <= req_wdata;
              s_wstrb <= req_wstrb;
            end
          end
        end
        ACCESS: begin
          if (ack_hit) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_rdata <= s_we ? '0 : sel_rdata;
            s_sel      <= '0;
          end else if (cnt == TO_LAST) begin
            state      <= RESP;
            resp_valid <= 1'b1;
            resp_err   <= 1'b1;
            s_sel      <= '0;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_decoder.sv
// tb_bus_decoder: directed checks of decode, faults, timeout,
// ack/timeout tie, stray acks, reset abort and counter saturation.
module tb_bus_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        req_we;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [2:0]  s_sel;
  logic [31:0] s_addr;
  logic        s_we;
  logic [31:0] s_wdata;
  logic [3:0]  s_wstrb;
  logic [2:0]  s_ack;
  logic [95:0] s_rdata;
  logic [7:0]  err_count;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bus_decoder dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_we     (req_we),
    .req_wdata  (req_wdata),
    .req_wstrb  (req_wstrb),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .s_sel      (s_sel),
    .s_addr     (s_addr),
    .s_we       (s_we),
    .s_wdata    (s_wdata),
    .s_wstrb    (s_wstrb),
    .s_ack      (s_ack),
    .s_rdata    (s_rdata),
    .err_count  (err_count)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] a, input logic we,
                       input logic [31:0] wd, input logic [3:0] ws);
    req_valid = 1'b1;
    req_addr  = a;
    req_we    = we;
    req_wdata = wd;
    req_wstrb = ws;
    tick();
    req_valid = 1'b0;
    req_addr  = '0;
    req_we    = 1'b0;
    req_wdata = '0;
    req_wstrb = '0;
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 1'b0;
    req_addr = '0;
    req_we = 1'b0;
    req_wdata = '0;
    req_wstrb = '0;
    s_ack = '0;
    s_rdata = '0;
    tick();
    tick();
    chk("rst_ready", 64'(req_ready), 64'd1);
    chk("rst_valid", 64'(resp_valid), 64'd0);
    chk("rst_err", 64'(resp_err), 64'd0);
    chk("rst_rdata", 64'(resp_rdata), 64'd0);
    chk("rst_sel", 64'(s_sel), 64'd0);
    chk("rst_addr", 64'(s_addr), 64'd0);
    chk("rst_we", 64'(s_we), 64'd0);
    chk("rst_wdata", 64'(s_wdata), 64'd0);
    chk("rst_wstrb", 64'(s_wstrb), 64'd0);
    chk("rst_errcnt", 64'(err_count), 64'd0);
    rst = 1'b0;
    tick();

    // read hit region 1, ack in cycle 1
    issue(32'h8000_2010, 1'b0, 32'h0, 4'h0);
    chk("r1_sel", 64'(s_sel), 64'h2);
    chk("r1_addr", 64'(s_addr), 64'h10);
    chk("r1_we", 64'(s_we), 64'd0);
    chk("r1_ready", 64'(req_ready), 64'd0);
    s_ack = 3'b010;
    s_rdata[32 +: 32] = 32'hDEAD_BEEF;
    tick();
    s_ack = '0;
    chk("r1_rvalid", 64'(resp_valid), 64'd1);
    chk("r1_rdata", 64'(resp_rdata), 64'hDEAD_BEEF);
    chk("r1_rerr", 64'(resp_err), 64'd0);
    chk("r1_seloff", 64'(s_sel), 64'd0);
    tick();
    chk("r1_pulse", 64'(resp_valid), 64'd0);
    chk("r1_ready2", 64'(req_ready), 64'd1);

    // UART write (region 2), stray ack, ack in cycle 3
    issue(32'h4000_0003, 1'b1, 32'h41, 4'b1000);
    chk("uw_sel", 64'(s_sel), 64'h4);
    chk("uw_addr", 64'(s_addr), 64'h3);
    chk("uw_we", 64'(s_we), 64'd1);
    chk("uw_wdata", 64'(s_wdata), 64'h41);
    chk("uw_wstrb", 64'(s_wstrb), 64'h8);
    tick();
    s_ack = 3'b011;
    s_rdata[0 +: 32] = 32'h1111_1111;
    tick();
    chk("stray_valid", 64'(resp_valid), 64'd0);
    chk("stray_sel", 64'(s_sel), 64'h4);
    s_ack = 3'b100;
    s_rdata[64 +: 32] = 32'h1234_5678;
    tick();
    s_ack = '0;
    chk("uw_rvalid", 64'(resp_valid), 64'd1);
    chk("uw_rerr", 64'(resp_err), 64'd0);
    chk("uw_rdata", 64'(resp_rdata), 64'd0);
    tick();

    // decode miss
    issue(32'h1234_0000, 1'b0, 32'h0, 4'h0);
    chk("miss_valid", 64'(resp_valid), 64'd1);
    chk("miss_err", 64'(resp_err), 64'd1);
    chk("miss_sel", 64'(s_sel), 64'd0);
    chk("miss_rdata", 64'(resp_rdata), 64'd0);
    tick();
    chk("miss_cnt", 64'(err_count), 64'd1);

    // write to read-only PROM
    issue(32'h8000_0004, 1'b1, 32'h55, 4'hF);
    chk("ro_valid", 64'(resp_valid), 64'd1);
    chk("ro_err", 64'(resp_err), 64'd1);
    chk("ro_sel", 64'(s_sel), 64'd0);
    tick();
    chk("ro_cnt", 64'(err_count), 64'd2);

    // timeout on region 2
    issue(32'h4000_0000, 1'b0, 32'h0, 4'h0);
    for (int c = 1; c <= 16; c++) begin
      chk("to_wait", 64'({s_sel, resp_valid}), 64'b1000);
      tick();
    end
    chk("to_valid", 64'(resp_valid), 64'd1);
    chk("to_err", 64'(resp_err), 64'd1);
    chk("to_sel", 64'(s_sel), 64'd0);
    tick();
    chk("to_cnt", 64'(err_count), 64'd3);

    // ack in the timeout cycle wins
    issue(32'h8000_2000, 1'b0, 32'h0, 4'h0);
    for (int c = 1; c <= 15; c++) begin
      chk("tie_wait", 64'({s_sel, resp_valid}), 64'b0100);
      tick();
    end
    s_ack = 3'b010;
    s_rdata[32 +: 32] = 32'hCAFE_F00D;
    tick();
    s_ack = '0;
    chk("tie_valid", 64'(resp_valid), 64'd1);
    chk("tie_err", 64'(resp_err), 64'd0);
    chk("tie_rdata", 64'(resp_rdata), 64'hCAFE_F00D);
    tick();
    chk("tie_cnt", 64'(err_count), 64'd3);

    // reset while in ACCESS
    issue(32'h8000_0008, 1'b0, 32'h0, 4'h0);
    chk("ra_sel", 64'(s_sel), 64'h1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("ra_sel0", 64'(s_sel), 64'd0);
    chk("ra_valid", 64'(resp_valid), 64'd0);
    chk("ra_cnt", 64'(err_count), 64'd0);
    chk("ra_ready", 64'(req_ready), 64'd1);
    tick();
    chk("ra_quiet", 64'(resp_valid), 64'd0);
    issue(32'h8000_1FFC, 1'b0, 32'h0, 4'h0);
    chk("ra2_sel", 64'(s_sel), 64'h1);
    chk("ra2_addr", 64'(s_addr), 64'h1FFC);
    s_ack = 3'b001;
    s_rdata[0 +: 32] = 32'h0BAD_F00D;
    tick();
    s_ack = '0;
    chk("ra2_valid", 64'(resp_valid), 64'd1);
    chk("ra2_err", 64'(resp_err), 64'd0);
    chk("ra2_rdata", 64'(resp_rdata), 64'h0BAD_F00D);
    tick();

    // err_count saturates at 255
    for (int n = 0; n < 260; n++) begin
      issue(32'h0000_0100, 1'b0, 32'h0, 4'h0);
      tick();
    end
    chk("sat_cnt", 64'(err_count), 64'd255);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
